q_bus_arbiter: RTL
==================

# q_bus_arbiter

Round-robin arbiter and sequencer for the shared 16-bit Q bus inside the `test` hierarchy. Several instances (`a`, `b`, …) are currently wired to drive Q at the same time. This block grants Q to exactly one requester at a time, carries bursts of beats from that owner onto a registered Q output, and inserts a one-cycle turnaround between owners so that two drivers never overlap.

## Interface
Parameters:
- NREQ, 4: number of requesters; legal values are 2 and above.
- DW, 16: Q bus width in bits.
- MAXBEAT, 8: maximum beats per grant before the grant is forcibly released; legal values are 1 and above.

Ports:
- CLK  in  1  single clock; all logic updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NREQ  REQ[i] high means requester i wants the bus or presents a beat.
- LAST  in  NREQ  LAST[i] marks requester i's final beat; it is only sampled together with REQ[i] while i owns the bus.
- D  in  NREQ*DW  requester i drives D[i*DW+DW-1 : i*DW].
- GNT  out  NREQ  one-hot grant, registered; all zeros when no requester owns the bus.
- Q  out  DW  registered bus data.
- QV  out  1  Q holds a beat accepted on the previous edge.
- OWNER  out  clog2(NREQ)  index of the current or most recent owner.
- BUSY  out  1  high whenever state is not IDLE.

## Operation
States: IDLE, OWN, TURN. Internal registers:
- PTR, the round-robin pointer, clog2(NREQ) bits.
- BCNT, the beat counter, clog2(MAXBEAT+1) bits.

Reset values: state=IDLE, GNT=0, Q=0, QV=0, OWNER=0, BUSY=0, PTR=0, BCNT=0. RST has priority over every other event in every state.

Arbitration (IDLE and TURN):
- Select the first i with REQ[i]=1, searching PTR, PTR+1, … modulo NREQ.
- If a requester is found: GNT<=one-hot(i), OWNER<=i, BCNT<=0, state<=OWN.
- If none is found: state<=IDLE and GNT stays 0.

OWN, for owner o, on each edge:
- **Beat:** REQ[o]=1. Then Q<=D[o], QV<=1, BCNT<=BCNT+1.
  - Release if LAST[o]=1 or BCNT+1==MAXBEAT.
  - Otherwise stay in OWN.
- **Drop:** REQ[o]=0. No beat is taken: QV<=0, Q holds. Release.
- **Release actions:** GNT<=0, PTR<=(o+1) mod NREQ, state<=TURN.

TURN:
- GNT stays 0 for this one cycle.
- QV<=0 and Q holds its value.
- Arbitrate as described above, using the PTR value just updated.

In any cycle with no accepted beat, QV<=0 and Q keeps its last value.

Other rules:
- D and LAST from requesters that are not granted are ignored.
- REQ from other requesters during OWN has no effect until arbitration runs in TURN.
- If RST is asserted during OWN, GNT drops to 0 on that edge. Any in-flight burst is abandoned without a final beat, and PTR returns to 0.

## Timing
- Grant latency: REQ[i] is sampled high in IDLE on edge t, and GNT[i] is high from edge t onward. The first beat can be accepted on edge t+1.
- Beat to output: a beat accepted on edge t appears on Q with QV=1 in the cycle following edge t.
- Release: the edge that accepts the last beat, or that sees the drop, clears GNT. The next cycle is TURN with GNT=0, and the next GNT becomes visible after the TURN edge.
- Minimum gap between two owners' GNT is exactly 1 cycle.
- Sustained throughput is MAXBEAT beats per MAXBEAT+1 cycles when requesters change hands.
- The owner's REQ must stay high for every beat. Deasserting REQ ends the burst immediately.
- OWNER updates on the same edge as GNT and holds its value through TURN and IDLE.

## Test plan
- **Reset:** assert RST mid-burst (owner 2, BCNT=3) → next cycle GNT=0, QV=0, Q=0, OWNER=0, BUSY=0; then REQ=4'b0110 → GNT=4'b0010.
- **Round-robin:** hold REQ=4'b1111 with LAST=4'b1111 (1-beat bursts) → GNT sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- **Burst data:** requester 1 sends D=16'h0011, 16'h0022, 16'h0033 with LAST on the third beat → Q shows 0011, 0022, 0033 on three consecutive cycles with QV=1, then QV=0 and Q holds 0033.
- **Forced release:** MAXBEAT=8, requester 0 holds REQ with LAST=0 → exactly 8 beats, then GNT=0 for 1 cycle, then GNT=0001 again if requester 0 is the only one requesting.
- **Drop:** owner 3 deasserts REQ after 2 beats → QV=0 on the drop edge, TURN, PTR=0; pending REQ[0] and REQ[2] → GNT=0001.
- **Contention check:** assert that GNT is never more than one-hot and that QV=1 is never seen in the cycle after a TURN cycle.

Source files
------------

// File: rtl/q_bus_arbiter_if.sv
// Q bus bundle between the requesters (master side) and the arbiter (slave side).
// Handshake: a beat from owner o transfers on a rising edge when gnt[o] && req[o]; last[o] qualifies that beat only.
interface q_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ*DW-1:0] d;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      q;
  logic               qv;
  logic [OW-1:0]      owner;
  logic               busy;

  modport master (
    output req, last, d,
    input  gnt, q, qv, owner, busy
  );

  modport slave (
    input  req, last, d,
    output gnt, q, qv, owner, busy
  );
endinterface

// File: rtl/q_bus_arbiter.sv
// Round-robin owner for the shared Q bus: one grant at a time, registered beats,
// and a single TURN cycle between owners so two drivers never overlap.
module q_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int MAXBEAT = 8
) (
  input  logic                clk,
  input  logic                rst,
  q_bus_arbiter_if.slave      bus,
  output logic [1:0]          state_dbg
);
  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBEAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          state;
  logic [NREQ-1:0] gnt_r;
  logic [DW-1:0]   q_r;
  logic            qv_r;
  logic [OW-1:0]   owner_r;
  logic            busy_r;
  logic [OW-1:0]   ptr;
  logic [BW-1:0]   bcnt;

  logic            arb_found;
  logic [OW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_onehot;
  logic            own_req;
  logic            own_last;
  logic [DW-1:0]   own_d;
  logic [BW-1:0]   bcnt_inc;
  logic [OW-1:0]   ptr_next;

  // Search order starts at ptr and wraps, so the most recent owner goes last.
  always_comb begin
    int cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!arb_found && bus.req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = OW'(cand);
      end
    end
  end

  assign arb_onehot = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
  assign own_req    = bus.req[owner_r];
  assign own_last   = bus.last[owner_r];
  assign own_d      = bus.d[int'(owner_r)*DW +: DW];
  assign bcnt_inc   = bcnt + 1'b1;
  assign ptr_next   = (owner_r == OW'(NREQ-1)) ? '0 : owner_r + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gnt_r   <= '0;
      q_r     <= '0;
      qv_r    <= 1'b0;
      owner_r <= '0;
      busy_r  <= 1'b0;
      ptr     <= '0;
      bcnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_TURN: begin
          qv_r <= 1'b0;
          if (arb_found) begin
            gnt_r   <= arb_onehot;
            owner_r <= arb_idx;
            bcnt    <= '0;
            state   <= S_OWN;
            busy_r  <= 1'b1;
          end else begin
            gnt_r  <= '0;
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end
        end
        S_OWN: begin
          if (own_req) begin
            q_r  <= own_d;
            qv_r <= 1'b1;
            bcnt <= bcnt_inc;
            if (own_last || (bcnt_inc == BW'(MAXBEAT))) begin
              gnt_r <= '0;
              ptr   <= ptr_next;
              state <= S_TURN;
            end
          end else begin
            // Owner dropped REQ: burst ends here with no beat taken.
            qv_r  <= 1'b0;
            gnt_r <= '0;
            ptr   <= ptr_next;
            state <= S_TURN;
          end
        end
        default: begin
          state  <= S_IDLE;
          gnt_r  <= '0;
          qv_r   <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.q     = q_r;
  assign bus.qv    = qv_r;
  assign bus.owner = owner_r;
  assign bus.busy  = busy_r;
  assign state_dbg = state;
endmodule
